// File: rtl/mac_sequencer.sv
// mac_sequencer: control FSM for the 8x8 multiply / 20-bit accumulate
// datapath, stepping a dot product of programmable length.
module mac_sequencer #(
  parameter int COUNT_W = 8,
  parameter int SETTLE  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [7:0]         op_a,
  input  logic [7:0]         op_b,
  output logic [7:0]         dp_a,
  output logic [7:0]         dp_b,
  output logic               dp_add,
  output logic               dp_clear,
  input  logic [19:0]        dp_result,
  input  logic               dp_carry,
  output logic               busy,
  output logic [COUNT_W-1:0] count,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [19:0]        result,
  output logic               overflow
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] MULT    = 3'd3;
  localparam logic [2:0] ACCUM   = 3'd4;
  localparam logic [2:0] CHECK   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [2:0]         state;
  logic [COUNT_W-1:0] len_q;
  logic [3:0]         settle;
  logic [COUNT_W-1:0] count_inc;

  assign count_inc = count + 1'b1;

  assign op_ready  = (state == WAIT_OP);
  assign dp_add    = (state == MULT);
  assign dp_clear  = reset | (state == CLEAR);
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      settle   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      result   <= '0;
      dp_a     <= '0;
      dp_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            count    <= '0;
            overflow <= 1'b0;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          if (len_q == '0) begin
            result <= '0;
            state  <= DONE;
          end else begin
            state <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (op_valid) begin
            dp_a   <= op_a;
            dp_b   <= op_b;
            settle <= '0;
            state  <= MULT;
          end
        end
        MULT: begin
          if (settle == SETTLE_LAST) begin
            state <= ACCUM;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        ACCUM: begin
          state <= CHECK;
        end
        CHECK: begin
          // carry is valid only in the cycle right after the accumulate
          overflow <= overflow | dp_carry;
          count    <= count_inc;
          if (count_inc == len_q) begin
            result <= dp_result;
            state  <= DONE;
          end else begin
            state <= WAIT_OP;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
